// File: rtl/ovl_fire_reporter.sv
// ovl_fire_reporter: collects per-cycle OVL checker fire strobes, timestamps each
// firing cycle into a small FIFO drained over a valid/ready report port, and keeps
// saturating fire/drop statistics plus the id of the first recorded firing checker.
module ovl_fire_reporter #(
  parameter int unsigned NUM_CHECKS = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TS_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned ID_WIDTH  = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_CHECKS-1:0] fire,
  input  logic                  clear_stats,
  output logic                  rpt_valid,
  input  logic                  rpt_ready,
  output logic [NUM_CHECKS-1:0] rpt_fire,
  output logic [TS_WIDTH-1:0]   rpt_ts,
  output logic [CNT_WIDTH-1:0]  total_fires,
  output logic [CNT_WIDTH-1:0]  dropped,
  output logic                  overflow,
  output logic [ID_WIDTH-1:0]   first_fire_id,
  output logic                  first_valid
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [TS_WIDTH-1:0]   ts_q;
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic [NUM_CHECKS-1:0] fire_mem [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]   ts_mem   [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0]  total_q, total_d, dropped_q, dropped_d;
  logic                  overflow_q, overflow_d, first_valid_q, first_valid_d;
  logic [ID_WIDTH-1:0]   first_id_q, first_id_d, low_idx;
  logic                  empty, full, push_try, push_ok, pop, drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_try = enable && (|fire);
  assign pop      = !empty && rpt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok  = push_try && (!full || pop);
  assign drop     = push_try && full && !pop;

  // No bypass: head fields come only from stored entries, zero when empty.
  assign rpt_valid = !empty;
  assign rpt_fire  = empty ? '0 : fire_mem[rd_ptr_q[AW-1:0]];
  assign rpt_ts    = empty ? '0 : ts_mem[rd_ptr_q[AW-1:0]];

  assign total_fires   = total_q;
  assign dropped       = dropped_q;
  assign overflow      = overflow_q;
  assign first_fire_id = first_id_q;
  assign first_valid   = first_valid_q;

  // Free-running timestamp and FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Record storage; contents are only observable through valid pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fire_mem[wr_ptr_q[AW-1:0]] <= fire;
      ts_mem[wr_ptr_q[AW-1:0]]   <= ts_q;
    end
  end

  // Lowest set bit of the fire vector.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (fire[i]) low_idx = ID_WIDTH'(i);
    end
  end

  // Statistics next state; clear_stats overrides any same-cycle update.
  always_comb begin
    total_d       = total_q;
    dropped_d     = dropped_q;
    overflow_d    = overflow_q;
    first_valid_d = first_valid_q;
    first_id_d    = first_id_q;
    if (clear_stats) begin
      total_d       = '0;
      dropped_d     = '0;
      overflow_d    = 1'b0;
      first_valid_d = 1'b0;
      first_id_d    = '0;
    end else begin
      if (push_try && (total_q != '1)) total_d = total_q + CNT_WIDTH'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (dropped_q != '1) dropped_d = dropped_q + CNT_WIDTH'(1);
      end
      if (push_ok && !first_valid_q) begin
        first_valid_d = 1'b1;
        first_id_d    = low_idx;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      total_q       <= '0;
      dropped_q     <= '0;
      overflow_q    <= 1'b0;
      first_valid_q <= 1'b0;
      first_id_q    <= '0;
    end else begin
      total_q       <= total_d;
      dropped_q     <= dropped_d;
      overflow_q    <= overflow_d;
      first_valid_q <= first_valid_d;
      first_id_q    <= first_id_d;
    end
  end

endmodule

// File: tb/tb_ovl_fire_reporter.sv
// Directed self-checking bench for ovl_fire_reporter; a second instance built with
// CNT_WIDTH=4 shares the stimulus and is used for counter saturation.
module tb_ovl_fire_reporter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [7:0]  fire = '0;
  logic        clear_stats = 1'b0;
  logic        rpt_ready = 1'b0;
  logic        rpt_valid;
  logic [7:0]  rpt_fire;
  logic [31:0] rpt_ts;
  logic [15:0] total_fires, dropped;
  logic        overflow, first_valid;
  logic [2:0]  first_fire_id;

  logic        s_valid, s_overflow, s_first_valid;
  logic [7:0]  s_fire;
  logic [31:0] s_ts;
  logic [3:0]  s_total, s_dropped;
  logic [2:0]  s_first_id;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ovl_fire_reporter #(.NUM_CHECKS(8), .FIFO_DEPTH(4), .TS_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fire(fire), .clear_stats(clear_stats),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_fire(rpt_fire), .rpt_ts(rpt_ts),
    .total_fires(total_fires), .dropped(dropped), .overflow(overflow),
    .first_fire_id(first_fire_id), .first_valid(first_valid)
  );

  ovl_fire_reporter #(.NUM_CHECKS(8), .FIFO_DEPTH(4), .TS_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fire(fire), .clear_stats(clear_stats),
    .rpt_valid(s_valid), .rpt_ready(rpt_ready), .rpt_fire(s_fire), .rpt_ts(s_ts),
    .total_fires(s_total), .dropped(s_dropped), .overflow(s_overflow),
    .first_fire_id(s_first_id), .first_valid(s_first_valid)
  );

  always #5 clk = ~clk;

  // After each tick, cyc equals the timestamp the DUT will sample on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; enable = 1'b1; fire = '0; clear_stats = 1'b0; rpt_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", rpt_valid); end
    total++; if (rpt_fire !== 8'h0) begin bad++; $display("FAIL rst_fire got=%0h want=0", rpt_fire); end
    total++; if (rpt_ts !== 32'h0) begin bad++; $display("FAIL rst_ts got=%0h want=0", rpt_ts); end
    total++; if (total_fires !== 16'h0) begin bad++; $display("FAIL rst_total got=%0h want=0", total_fires); end
    total++; if (dropped !== 16'h0) begin bad++; $display("FAIL rst_dropped got=%0h want=0", dropped); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0h want=0", overflow); end
    total++; if (first_valid !== 1'b0 || first_fire_id !== 3'd0) begin bad++;
      $display("FAIL rst_first got=%0h/%0h want=0/0", first_valid, first_fire_id); end
  endtask

  task automatic test_latency();
    apply_reset();
    repeat (5) tick();
    fire = 8'h04; rpt_ready = 1'b1;
    tick();
    fire = 8'h00;
    total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%0h want=1", rpt_valid); end
    total++; if (rpt_fire !== 8'h04) begin bad++; $display("FAIL lat_fire got=%0h want=04", rpt_fire); end
    total++; if (rpt_ts !== 32'd5) begin bad++; $display("FAIL lat_ts got=%0d want=5", rpt_ts); end
    total++; if (total_fires !== 16'd1) begin bad++; $display("FAIL lat_total got=%0d want=1", total_fires); end
    total++; if (first_valid !== 1'b1 || first_fire_id !== 3'd2) begin bad++;
      $display("FAIL lat_first got=%0h/%0d want=1/2", first_valid, first_fire_id); end
    tick();
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL lat_pop got=%0h want=0", rpt_valid); end
  endtask

  task automatic test_overflow();
    apply_reset();
    rpt_ready = 1'b0; fire = 8'h01;
    repeat (6) tick();
    fire = 8'h00;
    total++; if (dropped !== 16'd2) begin bad++; $display("FAIL ovf_dropped got=%0d want=2", dropped); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0h want=1", overflow); end
    total++; if (total_fires !== 16'd6) begin bad++; $display("FAIL ovf_total got=%0d want=6", total_fires); end
    rpt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (rpt_valid !== 1'b1 || rpt_ts !== 32'(i)) begin bad++;
        $display("FAIL ovf_drain%0d got=%0h/%0d want=1/%0d", i, rpt_valid, rpt_ts, i); end
      tick();
    end
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0h want=0", rpt_valid); end
    rpt_ready = 1'b0;
  endtask

  task automatic test_full_pop_push();
    apply_reset();
    rpt_ready = 1'b0; fire = 8'h01;
    repeat (4) tick();
    // FIFO now holds ts 0..3; pop the head and push 0x80 (ts 4) together.
    rpt_ready = 1'b1; fire = 8'h80;
    tick();
    fire = 8'h00;
    total++; if (dropped !== 16'd0 || overflow !== 1'b0) begin bad++;
      $display("FAIL fpp_drop got=%0d/%0h want=0/0", dropped, overflow); end
    total++; if (total_fires !== 16'd5) begin bad++; $display("FAIL fpp_total got=%0d want=5", total_fires); end
    for (int i = 1; i < 5; i++) begin
      total++; if (rpt_valid !== 1'b1 || rpt_ts !== 32'(i) || rpt_fire !== ((i == 4) ? 8'h80 : 8'h01)) begin
        bad++; $display("FAIL fpp_drain%0d got=%0h/%0d/%0h want=1/%0d", i, rpt_valid, rpt_ts, rpt_fire, i); end
      tick();
    end
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%0h want=0", rpt_valid); end
  endtask

  task automatic test_first_id();
    apply_reset();
    rpt_ready = 1'b1;
    fire = 8'h18; tick();
    fire = 8'h02; tick();
    fire = 8'h00; tick();
    total++; if (first_valid !== 1'b1 || first_fire_id !== 3'd3) begin bad++;
      $display("FAIL first_id got=%0h/%0d want=1/3", first_valid, first_fire_id); end
    total++; if (total_fires !== 16'd2) begin bad++; $display("FAIL first_total got=%0d want=2", total_fires); end
  endtask

  task automatic test_clear();
    apply_reset();
    rpt_ready = 1'b0;
    fire = 8'h04; tick();
    clear_stats = 1'b1; fire = 8'h01; tick();
    clear_stats = 1'b0; fire = 8'h00;
    total++; if (total_fires !== 16'd0) begin bad++; $display("FAIL clr_total got=%0d want=0", total_fires); end
    total++; if (first_valid !== 1'b0 || first_fire_id !== 3'd0) begin bad++;
      $display("FAIL clr_first got=%0h/%0d want=0/0", first_valid, first_fire_id); end
    total++; if (rpt_valid !== 1'b1 || rpt_fire !== 8'h04) begin bad++;
      $display("FAIL clr_head got=%0h/%0h want=1/04", rpt_valid, rpt_fire); end
    rpt_ready = 1'b1; tick(); rpt_ready = 1'b0;
    total++; if (rpt_valid !== 1'b1 || rpt_fire !== 8'h01 || rpt_ts !== 32'd1) begin bad++;
      $display("FAIL clr_rec got=%0h/%0h/%0d want=1/01/1", rpt_valid, rpt_fire, rpt_ts); end
    fire = 8'h40; tick(); fire = 8'h00;
    total++; if (first_valid !== 1'b1 || first_fire_id !== 3'd6) begin bad++;
      $display("FAIL clr_recap got=%0h/%0d want=1/6", first_valid, first_fire_id); end
    // Fill to full, then clear alongside a push that is dropped.
    fire = 8'h01; repeat (2) tick();
    clear_stats = 1'b1; tick();
    clear_stats = 1'b0; fire = 8'h00;
    total++; if (dropped !== 16'd0 || overflow !== 1'b0 || total_fires !== 16'd0) begin bad++;
      $display("FAIL clr_drop got=%0d/%0h/%0d want=0/0/0", dropped, overflow, total_fires); end
  endtask

  task automatic test_enable();
    apply_reset();
    rpt_ready = 1'b0; enable = 1'b0; fire = 8'hFF;
    repeat (3) tick();
    total++; if (rpt_valid !== 1'b0 || total_fires !== 16'd0 || first_valid !== 1'b0) begin bad++;
      $display("FAIL en_ignore got=%0h/%0d/%0h want=0/0/0", rpt_valid, total_fires, first_valid); end
    enable = 1'b1; fire = 8'h01; tick();
    enable = 1'b0; fire = 8'hFF; rpt_ready = 1'b1; tick();
    total++; if (rpt_valid !== 1'b0 || total_fires !== 16'd1) begin bad++;
      $display("FAIL en_drain got=%0h/%0d want=0/1", rpt_valid, total_fires); end
    enable = 1'b1; fire = 8'h00; rpt_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rpt_ready = 1'b0; fire = 8'h01;
    repeat (3) tick();
    fire = 8'h00;
    total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0h want=1", rpt_valid); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (rpt_valid !== 1'b0 || rpt_fire !== 8'h0) begin bad++;
      $display("FAIL mid_async got=%0h/%0h want=0/0", rpt_valid, rpt_fire); end
    total++; if (total_fires !== 16'd0 || first_valid !== 1'b0) begin bad++;
      $display("FAIL mid_stats got=%0d/%0h want=0/0", total_fires, first_valid); end
    @(negedge clk);
    reset_n = 1'b1; cyc = 0;
    fire = 8'h02; tick(); fire = 8'h00;
    total++; if (rpt_valid !== 1'b1 || rpt_ts !== 32'd0 || rpt_fire !== 8'h02) begin bad++;
      $display("FAIL mid_ts got=%0h/%0d/%0h want=1/0/02", rpt_valid, rpt_ts, rpt_fire); end
  endtask

  task automatic test_saturate();
    apply_reset();
    rpt_ready = 1'b1; fire = 8'h01;
    repeat (20) tick();
    total++; if (s_total !== 4'd15) begin bad++; $display("FAIL sat_total4 got=%0d want=15", s_total); end
    total++; if (total_fires !== 16'd20) begin bad++; $display("FAIL sat_total16 got=%0d want=20", total_fires); end
    // One entry remains; 3 more fit, the other 21 are dropped.
    rpt_ready = 1'b0;
    repeat (24) tick();
    fire = 8'h00;
    total++; if (s_dropped !== 4'd15 || s_overflow !== 1'b1) begin bad++;
      $display("FAIL sat_drop4 got=%0d/%0h want=15/1", s_dropped, s_overflow); end
    total++; if (dropped !== 16'd21) begin bad++; $display("FAIL sat_drop16 got=%0d want=21", dropped); end
    total++; if (s_total !== 4'd15 || total_fires !== 16'd44) begin bad++;
      $display("FAIL sat_hold got=%0d/%0d want=15/44", s_total, total_fires); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_full_pop_push();
    test_first_id();
    test_clear();
    test_enable();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ovl_fire_reporter.md
Name: ovl_fire_reporter

Overview:
- Downstream of the OVL checker instances (always_on_edge assert/assume bindings and siblings).
- Consumes their per-cycle fire strobes, timestamps each firing cycle and queues it in a small FIFO.
- Presents queued records on a valid/ready report port and keeps saturating fire statistics.
- Sits between the checker layer and the simulation/emulation log collector.

Parameters:
- NUM_CHECKS, 8, number of checker fire inputs aggregated.
- FIFO_DEPTH, 4, report FIFO entries; power of two, at least 2.
- TS_WIDTH, 32, width of the free-running cycle timestamp.
- CNT_WIDTH, 16, width of the saturating total-fire and dropped-record counters.

Ports:
- clk  input  1  sampling clock shared with the checkers.
- reset_n  input  1  reset, asynchronous, active-low.
- enable  input  1  collection enable; fire ignored while low.
- fire  input  NUM_CHECKS  per-checker fire strobes, one bit per checker, active-high, single-cycle.
- clear_stats  input  1  synchronous clear of counters and sticky flags.
- rpt_valid  output  1  a report record is available.
- rpt_ready  input  1  consumer accepts the record.
- rpt_fire  output  NUM_CHECKS  fire vector of the head record.
- rpt_ts  output  TS_WIDTH  timestamp of the head record.
- total_fires  output  CNT_WIDTH  saturating count of cycles with any fire accepted.
- dropped  output  CNT_WIDTH  saturating count of records lost to a full FIFO.
- overflow  output  1  sticky: at least one record dropped.
- first_fire_id  output  clog2(NUM_CHECKS) (min 1)  lowest-index checker of the first recorded firing.
- first_valid  output  1  first_fire_id is valid.

Behaviour:
- Reset (async assert, sync deassert of internal state): FIFO empty.
- All outputs are 0 during and after reset: rpt_valid, rpt_fire, rpt_ts, total_fires, dropped, overflow, first_fire_id, first_valid.
- Timestamp: ts counter resets to 0 and increments every cycle. It wraps modulo 2^TS_WIDTH with no flag. A record carries the ts value of the cycle fire was sampled.
- Push: occurs when enable=1 and fire != 0. Record = {fire, ts}.
  - total_fires increments (saturating at all-ones) on every push attempt, whether or not the FIFO has room.
- Full FIFO on a push attempt:
  - The record is dropped.
  - dropped increments (saturating) and overflow sets.
  - An existing entry is never overwritten.
- Simultaneous push and pop while full: the pop frees a slot in the same cycle, so the push is accepted. No drop, no overflow.
- Simultaneous push and pop while empty: the record is accepted. Bypass is not allowed: rpt_valid rises one cycle after the fire cycle. Minimum latency fire->rpt_valid = 1 cycle.
- Pop: occurs when rpt_valid && rpt_ready.
  - rpt_fire and rpt_ts always show the head entry and are held stable while rpt_valid=1 and rpt_ready=0.
  - When empty, rpt_valid=0 and rpt_fire/rpt_ts are 0.
- First fire: on the first accepted push after reset or clear_stats, first_fire_id = index of the lowest set bit of fire, and first_valid=1. Both are held until reset or clear_stats.
- clear_stats=1: next cycle total_fires=0, dropped=0, overflow=0, first_valid=0, first_fire_id=0. FIFO contents and ts are unaffected.
- clear_stats coincident with a push:
  - The clear wins for the counters: total_fires=0, and dropped=0 even if that push is dropped.
  - The push still enters the FIFO if there is room.
  - first_* is not captured in that cycle.
- enable=0: fire is ignored entirely, with no counting and no push. The FIFO still drains.
- Reset mid-operation: all queued records are discarded immediately (asynchronously). rpt_valid drops in the same cycle.
- FIFO implementation: read/write pointers with one extra wrap bit; full/empty come from the pointer compare; count is never negative.

Test Plan:
- Reset, then fire=8'b0000_0100 at ts=5, rpt_ready=1 -> cycle ts=6: rpt_valid=1, rpt_fire=0x04, rpt_ts=5; total_fires=1, first_fire_id=2, first_valid=1.
- rpt_ready=0, fire=0x01 on 6 consecutive cycles with FIFO_DEPTH=4 -> 4 records queued, dropped=2, overflow=1, total_fires=6. Raising rpt_ready then drains 4 records in ts order.
- FIFO full, pop and fire=0x80 in the same cycle -> no drop; the new record is the tail; dropped unchanged.
- fire=0x18 then fire=0x02 -> first_fire_id=3 (lowest set bit of the first record) and remains 3.
- Pulse clear_stats in the same cycle as fire=0x01 with room -> next cycle total_fires=0, first_valid=0; record present in FIFO.
- enable=0 with fire=0xFF -> nothing queued, counters unchanged.
- Assert reset_n=0 while 3 records are queued -> rpt_valid=0 immediately; after release all stats=0 and ts restarts at 0.
- Force total_fires to all-ones via long stimulus (CNT_WIDTH=4 build) -> holds 15 on further fires.
